// File: rtl/uart_arb_pkg.sv
// Shared types and sizing for the UART transmit arbiter slice.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } arb_state_t;

   localparam int NUM_REQ_MIN = 2;
   localparam int NUM_REQ_MAX = 8;
   localparam int PTR_W       = $clog2(NUM_REQ_MAX);
   localparam int PTR_SLOTS   = 1 << PTR_W;

endpackage

// File: rtl/uart_rr_picker.sv
// Rotate-priority encoder: first asserted Req searching Ptr+1, Ptr+2, ... modulo NUM_REQ.
module uart_rr_picker
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
)(
   input  logic [NUM_REQ-1:0] Req,
   input  logic [PTR_W-1:0]   Ptr,
   output logic [PTR_W-1:0]   Win,
   output logic               Valid
);

   logic [NUM_REQ-1:0] above_ptr;
   logic [NUM_REQ-1:0] req_above;
   logic [NUM_REQ-1:0] sel;
   logic [NUM_REQ-1:0] lowest;
   logic [NUM_REQ-1:0] idx_bit [PTR_W];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign above_ptr[i] = (Ptr < PTR_W'(i));
      for (genvar b = 0; b < PTR_W; b++) begin : g_bit
         assign idx_bit[b][i] = (((i >> b) & 1) == 1);
      end
   end

   // Requests above Ptr win first; otherwise the search wraps to the lowest index.
   assign req_above = Req & above_ptr;
   assign sel       = (|req_above) ? req_above : Req;
   // Two's-complement trick isolates the lowest set bit.
   assign lowest    = sel & (~sel + NUM_REQ'(1));

   for (genvar b = 0; b < PTR_W; b++) begin : g_win
      assign Win[b] = |(lowest & idx_bit[b]);
   end

   assign Valid = |Req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ clients.
// Optional start timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int DATA_BITS     = 8,
   parameter int START_TIMEOUT = 64
)(
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic [NUM_REQ-1:0]           Req,
   input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
   output logic [NUM_REQ-1:0]           Ack,
   output logic [NUM_REQ-1:0]           Grant,
   output logic [DATA_BITS-1:0]         Tx_Data,
   output logic                         Transmit_Start,
   input  logic                         Tx_Busy,
   input  logic                         BIST_Busy,
   output logic                         Arb_Busy,
   output logic                         Timeout_Err
);

   if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
      $error("uart_tx_arbiter: NUM_REQ must be within 2..8");
   end
   if (START_TIMEOUT < 1) begin : g_bad_timeout
      $error("uart_tx_arbiter: START_TIMEOUT must be at least 1");
   end

   arb_state_t           state;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     win_q;
   logic [PTR_W-1:0]     pick_win;
   logic                 pick_valid;
   logic [DATA_BITS-1:0] lane_data [PTR_SLOTS];

   // Padding unused slots keeps the payload mux indexable by the full pointer width.
   for (genvar i = 0; i < PTR_SLOTS; i++) begin : g_lane
      if (i < NUM_REQ) begin : g_used
         assign lane_data[i] = Req_Data[i*DATA_BITS +: DATA_BITS];
      end else begin : g_pad
         assign lane_data[i] = '0;
      end
   end

   uart_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .Req   (Req),
      .Ptr   (ptr),
      .Win   (pick_win),
      .Valid (pick_valid)
   );

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);
   logic [CNT_W-1:0] start_cnt;
`else
   assign Timeout_Err = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state          <= IDLE;
         ptr            <= PTR_W'(NUM_REQ - 1);
         win_q          <= '0;
         Grant          <= '0;
         Ack            <= '0;
         Tx_Data        <= '0;
         Transmit_Start <= 1'b0;
         Arb_Busy       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         start_cnt      <= '0;
         Timeout_Err    <= 1'b0;
`endif
      end else begin
         // NOTE: pulse outputs default low here so every path leaves them defined.
         Ack <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         Timeout_Err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (pick_valid && !Tx_Busy && !BIST_Busy) begin
                  state          <= START;
                  Grant          <= NUM_REQ'(1) << pick_win;
                  win_q          <= pick_win;
                  Tx_Data        <= lane_data[pick_win];
                  Transmit_Start <= 1'b1;
                  Arb_Busy       <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                  start_cnt      <= '0;
`endif
               end
            end
            START: begin
               if (Tx_Busy) begin
                  state          <= BUSY;
                  Ack            <= Grant;
                  Transmit_Start <= 1'b0;
                  ptr            <= win_q;
               end
`ifdef UART_ARB_TIMEOUT_EN
               // Abandon the start; the requester stays pending behind the others.
               else if (start_cnt == CNT_W'(START_TIMEOUT - 1)) begin
                  state          <= IDLE;
                  Grant          <= '0;
                  Transmit_Start <= 1'b0;
                  Timeout_Err    <= 1'b1;
                  Arb_Busy       <= 1'b0;
                  ptr            <= win_q;
               end else begin
                  start_cnt <= start_cnt + CNT_W'(1);
               end
`endif
            end
            BUSY: begin
               if (!Tx_Busy) begin
                  state    <= IDLE;
                  Grant    <= '0;
                  Arb_Busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus scoreboard of accepted bytes.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ       = 4;
   localparam int DATA_BITS     = 8;
   localparam int START_TIMEOUT = 8;
   localparam int BUSY_DELAY    = 2;

   logic                         Clk = 1'b0;
   logic                         Rst;
   logic [NUM_REQ-1:0]           Req;
   logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
   logic [NUM_REQ-1:0]           Ack;
   logic [NUM_REQ-1:0]           Grant;
   logic [DATA_BITS-1:0]         Tx_Data;
   logic                         Transmit_Start;
   logic                         Tx_Busy;
   logic                         BIST_Busy;
   logic                         Arb_Busy;
   logic                         Timeout_Err;

   typedef struct packed {
      logic [NUM_REQ-1:0]   ack;
      logic [DATA_BITS-1:0] data;
   } xfer_t;

   typedef struct {
      logic [NUM_REQ-1:0]           req;
      logic [NUM_REQ*DATA_BITS-1:0] data;
      logic [NUM_REQ-1:0]           exp_grant;
      logic [DATA_BITS-1:0]         exp_data;
   } vec_t;

   xfer_t exp_q[$];
   xfer_t obs_q[$];
   int    checks    = 0;
   int    errors    = 0;
   int    grant_bad = 0;
   int    ack_wide  = 0;
   bit    stuck     = 1'b0;
   int    frame_len = 3;

   always #5 Clk = ~Clk;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .DATA_BITS     (DATA_BITS),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .Req            (Req),
      .Req_Data       (Req_Data),
      .Ack            (Ack),
      .Grant          (Grant),
      .Tx_Data        (Tx_Data),
      .Transmit_Start (Transmit_Start),
      .Tx_Busy        (Tx_Busy),
      .BIST_Busy      (BIST_Busy),
      .Arb_Busy       (Arb_Busy),
      .Timeout_Err    (Timeout_Err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic expect_xfer(input logic [NUM_REQ-1:0] g, input logic [DATA_BITS-1:0] d);
      exp_q.push_back({g, d});
   endtask

   task automatic wait_ack(input string name, output int ts_cycles);
      xfer_t e;
      xfer_t o;
      bit    got = 1'b0;
      ts_cycles = 0;
      for (int n = 0; n < 100 && !got; n++) begin
         if (obs_q.size() > 0) got = 1'b1;
         else begin
            if (Transmit_Start) ts_cycles++;
            tick();
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s: no Ack within 100 cycles", name);
      end else if (exp_q.size() == 0) begin
         o = obs_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: unexpected Ack %0h data %0h", name, o.ack, o.data);
      end else begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         check({name, " ack"}, 32'(o.ack), 32'(e.ack));
         check({name, " data"}, 32'(o.data), 32'(e.data));
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((Arb_Busy || Tx_Busy) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL %s: arbiter not idle within 100 cycles", name);
      end
   endtask

   // UART model: raises Tx_Busy BUSY_DELAY cycles into Transmit_Start, holds it frame_len cycles.
   initial begin : uart_model
      int start_cnt = 0;
      int frame_cnt = 0;
      Tx_Busy = 1'b0;
      forever begin
         @(posedge Clk);
         #1;
         if (Tx_Busy) begin
            frame_cnt--;
            if (frame_cnt == 0) Tx_Busy = 1'b0;
         end else if (Transmit_Start && !stuck) begin
            start_cnt++;
            if (start_cnt == BUSY_DELAY) begin
               Tx_Busy   = 1'b1;
               frame_cnt = frame_len;
               start_cnt = 0;
            end
         end else begin
            start_cnt = 0;
         end
      end
   end

   // Monitor: records accepted bytes and flags overlapping grants or wide Ack pulses.
   initial begin : monitor
      logic [NUM_REQ-1:0] prev_ack = '0;
      forever begin
         @(posedge Clk);
         #1;
         if ($countones(Grant) > 1) grant_bad++;
         if (Ack != '0 && prev_ack != '0) ack_wide++;
         if (Ack != '0) obs_q.push_back({Ack, Tx_Data});
         prev_ack = Ack;
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t vecs[12];
      int   ts;
      int   early;
      int   n_to;
      int   viol;

      vecs[0]  = '{4'b0001, 32'h0000_00A5, 4'b0001, 8'hA5};
      vecs[1]  = '{4'b1111, 32'h4433_2211, 4'b0010, 8'h22};
      vecs[2]  = '{4'b1111, 32'h4433_2211, 4'b0100, 8'h33};
      vecs[3]  = '{4'b1111, 32'h4433_2211, 4'b1000, 8'h44};
      vecs[4]  = '{4'b1111, 32'h8877_6655, 4'b0001, 8'h55};
      vecs[5]  = '{4'b1010, 32'hDEAD_BEEF, 4'b0010, 8'hBE};
      vecs[6]  = '{4'b1010, 32'hDEAD_BEEF, 4'b1000, 8'hDE};
      vecs[7]  = '{4'b1010, 32'hCAFE_F00D, 4'b0010, 8'hF0};
      vecs[8]  = '{4'b0100, 32'hCAFE_F00D, 4'b0100, 8'hFE};
      vecs[9]  = '{4'b0011, 32'h0102_0304, 4'b0001, 8'h04};
      vecs[10] = '{4'b1000, 32'h0102_0304, 4'b1000, 8'h01};
      vecs[11] = '{4'b1001, 32'h5A00_00C3, 4'b0001, 8'hC3};

      Rst       = 1'b1;
      Req       = '0;
      Req_Data  = '0;
      BIST_Busy = 1'b0;
      repeat (3) @(posedge Clk);
      #2;
      Rst = 1'b0;
      check("reset grant", 32'(Grant), 0);
      check("reset ack", 32'(Ack), 0);
      check("reset tx_data", 32'(Tx_Data), 0);
      check("reset start", 32'(Transmit_Start), 0);
      check("reset arb_busy", 32'(Arb_Busy), 0);
      check("reset timeout", 32'(Timeout_Err), 0);
      tick();

      // Single transfers from idle; the pointer carries over from row to row.
      for (int k = 0; k < 12; k++) begin
         wait_idle($sformatf("v%0d idle", k));
         Req      = vecs[k].req;
         Req_Data = vecs[k].data;
         expect_xfer(vecs[k].exp_grant, vecs[k].exp_data);
         tick();
         check($sformatf("v%0d grant", k), 32'(Grant), 32'(vecs[k].exp_grant));
         check($sformatf("v%0d start", k), 32'(Transmit_Start), 1);
         check($sformatf("v%0d arb_busy", k), 32'(Arb_Busy), 1);
         wait_ack($sformatf("v%0d", k), ts);
         check($sformatf("v%0d start_len", k), 32'(ts), BUSY_DELAY);
         Req = '0;
      end

      // Reset while BUSY, then held requests must restart from requester 0.
      wait_idle("rst idle");
      Req      = 4'b0100;
      Req_Data = 32'h9988_7766;
      expect_xfer(4'b0100, 8'h88);
      tick();
      wait_ack("rst xfer", ts);
      Req = '0;
      Rst = 1'b1;
      #1;
      check("rst busy grant", 32'(Grant), 0);
      check("rst busy ack", 32'(Ack), 0);
      check("rst busy tx_data", 32'(Tx_Data), 0);
      check("rst busy start", 32'(Transmit_Start), 0);
      check("rst busy arb_busy", 32'(Arb_Busy), 0);
      Rst = 1'b0;
      tick();

      Req      = 4'b1111;
      Req_Data = 32'h4433_2211;
      expect_xfer(4'b0001, 8'h11);
      expect_xfer(4'b0010, 8'h22);
      expect_xfer(4'b0100, 8'h33);
      expect_xfer(4'b1000, 8'h44);
      expect_xfer(4'b0001, 8'h11);
      for (int k = 0; k < 5; k++) begin
         wait_ack($sformatf("held%0d", k), ts);
         check($sformatf("held%0d start_len", k), 32'(ts), BUSY_DELAY);
      end
      Req = '0;

      // A request arriving while the UART is busy waits for Tx_Busy to fall.
      wait_idle("busy idle");
      frame_len = 10;
      Req       = 4'b0010;
      Req_Data  = 32'hF4F3_F2F1;
      expect_xfer(4'b0010, 8'hF2);
      tick();
      wait_ack("busy first", ts);
      Req = 4'b0100;
      expect_xfer(4'b0100, 8'hF3);
      early = 0;
      for (int n = 0; n < 50 && Tx_Busy; n++) begin
         tick();
         if (Transmit_Start || Grant == 4'b0100) early++;
      end
      check("busy no early start", 32'(early), 0);
      tick();
      check("busy release grant", 32'(Grant), 0);
      tick();
      check("busy next grant", 32'(Grant), 32'(4'b0100));
      check("busy next start", 32'(Transmit_Start), 1);
      wait_ack("busy second", ts);
      Req       = '0;
      frame_len = 3;

      // BIST ownership blocks new grants but not a transfer already underway.
      wait_idle("bist idle");
      BIST_Busy = 1'b1;
      Req       = 4'b0010;
      Req_Data  = 32'hC800_5500;
      for (int n = 0; n < 4; n++) begin
         tick();
         check($sformatf("bist hold grant%0d", n), 32'(Grant), 0);
         check($sformatf("bist hold arb_busy%0d", n), 32'(Arb_Busy), 0);
      end
      BIST_Busy = 1'b0;
      expect_xfer(4'b0010, 8'h55);
      tick();
      check("bist release grant", 32'(Grant), 32'(4'b0010));
      BIST_Busy = 1'b1;
      wait_ack("bist mid xfer", ts);
      Req = 4'b1000;
      wait_idle("bist mid idle");
      for (int n = 0; n < 3; n++) begin
         tick();
         check($sformatf("bist after grant%0d", n), 32'(Grant), 0);
      end
      BIST_Busy = 1'b0;
      expect_xfer(4'b1000, 8'hC8);
      tick();
      check("bist late grant", 32'(Grant), 32'(4'b1000));
      wait_ack("bist late xfer", ts);
      Req = '0;

      // UART never answers Transmit_Start.
      wait_idle("stuck idle");
      stuck    = 1'b1;
      Req      = 4'b0001;
      Req_Data = 32'h0000_003C;
      tick();
      check("stuck grant", 32'(Grant), 32'(4'b0001));
`ifdef UART_ARB_TIMEOUT_EN
      n_to = 0;
      while (!Timeout_Err && n_to < 50) begin
         tick();
         n_to++;
      end
      check("timeout cycle", 32'(n_to), START_TIMEOUT);
      check("timeout grant clear", 32'(Grant), 0);
      check("timeout start clear", 32'(Transmit_Start), 0);
      check("timeout no ack", 32'(obs_q.size()), 0);
      stuck = 1'b0;
      expect_xfer(4'b0001, 8'h3C);
      tick();
      check("timeout pulse width", 32'(Timeout_Err), 0);
      check("timeout regrant", 32'(Grant), 32'(4'b0001));
      wait_ack("timeout retry", ts);
`else
      viol = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (Timeout_Err || !Transmit_Start) viol++;
      end
      check("stuck start held", 32'(viol), 0);
      check("stuck no ack", 32'(obs_q.size()), 0);
      stuck = 1'b0;
      expect_xfer(4'b0001, 8'h3C);
      wait_ack("stuck release", ts);
`endif
      Req = '0;

      wait_idle("final idle");
      check("scoreboard expected left", 32'(exp_q.size()), 0);
      check("scoreboard observed left", 32'(obs_q.size()), 0);
      check("grant overlap", 32'(grant_bad), 0);
      check("ack pulse width", 32'(ack_wide), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
